count_1_pipe: RTL and testbench

COUNT_1_PIPE -- requirements
Module: count_1_pipe

---
 rtl/count_1_pkg.sv | 18 +
 rtl/count_1_lane.sv | 21 ++
 rtl/count_1_pipe.sv | 170 +++++++++++++++++
 tb/tb_count_1_pipe.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_1_pkg.sv
// count_1_pkg: FSM state type, mode encodings and width helpers shared by
// the popcount pipeline and its lane sub-module.
package count_1_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  localparam logic MODE_WORD  = 1'b0;
  localparam logic MODE_FRAME = 1'b1;

  // Bits needed to hold a population count of 'bits' bits (0..bits).
  function automatic int cnt_width(input int bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/count_1_lane.sv
// count_1_lane: purely combinational popcount of one LANE-bit slice.
module count_1_lane
  import count_1_pkg::*;
#(
  parameter int LANE = 8
) (
  input  logic [LANE-1:0]              lane_dat,
  output logic [cnt_width(LANE)-1:0]   lane_cnt
);

  localparam int CNT_W = cnt_width(LANE);

  // Add up the set bits of the slice one at a time.
  always_comb begin
    lane_cnt = '0;
    for (int i = 0; i < LANE; i++) begin
      lane_cnt = lane_cnt + CNT_W'(lane_dat[i]);
    end
  end

endmodule

// File: rtl/count_1_pipe.sv
// count_1_pipe: two-stage pipelined popcount. Stage 1 registers per-lane
// counts, stage 2 sums them and either emits the word count (mode 0) or
// accumulates it into a saturating per-frame total (mode 1). Frame decisions
// are made at acceptance time and travel down the pipe with the word.
module count_1_pipe
  import count_1_pkg::*;
#(
  parameter int IN_LEN  = 32,
  parameter int LANE    = 8,
  parameter int ACC_LEN = 16
) (
  input  logic                sys_clk,
  input  logic                in_rst_n,
  input  logic                in_mode,
  input  logic                in_vld,
  output logic                in_rdy,
  input  logic [IN_LEN-1:0]   in_dat,
  input  logic                in_sof,
  input  logic                in_eof,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic [ACC_LEN-1:0]  out_1_cnt,
  output logic                out_sat,
  output logic                out_drop
);

  localparam int NUM_LANES = IN_LEN / LANE;
  localparam int LANE_W    = cnt_width(LANE);
  localparam int CNT_W     = cnt_width(IN_LEN);

  state_t               state, state_nxt;
  logic                 mode_q, mode_nxt, mode_eff;
  logic                 stall, accept;
  logic                 dec_fwd, dec_clr, dec_emit, dec_word, dec_drop;

  logic [LANE_W-1:0]    lane_cnt [NUM_LANES];
  logic [LANE_W-1:0]    s1_lane  [NUM_LANES];
  logic                 s1_vld, s1_clr, s1_emit, s1_word;

  logic [CNT_W-1:0]     word_cnt;
  logic [ACC_LEN-1:0]   acc_q, acc_base, acc_nxt;
  logic [ACC_LEN:0]     acc_sum;
  logic                 sat_q, sat_nxt;

  // A held result freezes the whole pipe, so input is refused while it waits.
  assign stall  = out_vld && !out_rdy;
  assign in_rdy = !stall;
  assign accept = in_vld && in_rdy;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    count_1_lane #(.LANE(LANE)) u_lane (
      .lane_dat (in_dat[g*LANE +: LANE]),
      .lane_cnt (lane_cnt[g])
    );
  end

  // Frame state and the mode latched when a word is taken in IDLE.
  always_ff @(posedge sys_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state  <= IDLE;
      mode_q <= MODE_WORD;
    end else begin
      state  <= state_nxt;
      mode_q <= mode_nxt;
    end
  end

  // Decide per accepted word: forward, clear total, emit, or discard.
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    mode_eff  = (state == IDLE) ? in_mode : mode_q;
    dec_fwd   = 1'b0;
    dec_clr   = 1'b0;
    dec_emit  = 1'b0;
    dec_word  = 1'b0;
    dec_drop  = 1'b0;
    if (accept) begin
      if (state == IDLE) begin
        mode_nxt = in_mode;
      end
      unique case (mode_eff)
        MODE_WORD: begin
          dec_fwd  = 1'b1;
          dec_emit = 1'b1;
          dec_word = 1'b1;
        end
        MODE_FRAME: begin
          if (in_sof) begin
            dec_fwd   = 1'b1;
            dec_clr   = 1'b1;
            dec_emit  = in_eof;
            dec_drop  = (state == FRAME);
            state_nxt = in_eof ? IDLE : FRAME;
          end else if (state == FRAME) begin
            dec_fwd   = 1'b1;
            dec_emit  = in_eof;
            state_nxt = in_eof ? IDLE : FRAME;
          end else begin
            dec_drop  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage 1: capture lane counts plus the decision made for this word.
  always_ff @(posedge sys_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      s1_vld  <= 1'b0;
      s1_clr  <= 1'b0;
      s1_emit <= 1'b0;
      s1_word <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) s1_lane[i] <= '0;
    end else if (!stall) begin
      s1_vld  <= dec_fwd;
      s1_clr  <= dec_clr;
      s1_emit <= dec_emit;
      s1_word <= dec_word;
      for (int i = 0; i < NUM_LANES; i++) s1_lane[i] <= lane_cnt[i];
    end
  end

  // Word total and the saturating frame total it produces.
  always_comb begin
    word_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      word_cnt = word_cnt + CNT_W'(s1_lane[i]);
    end
    acc_base = s1_clr ? '0 : acc_q;
    acc_sum  = {1'b0, acc_base} + (ACC_LEN+1)'(word_cnt);
    acc_nxt  = acc_sum[ACC_LEN] ? '1 : acc_sum[ACC_LEN-1:0];
    sat_nxt  = acc_sum[ACC_LEN] || (sat_q && !s1_clr);
  end

  // Stage 2: update the accumulator and present results; frozen on stall.
  always_ff @(posedge sys_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      acc_q     <= '0;
      sat_q     <= 1'b0;
      out_vld   <= 1'b0;
      out_1_cnt <= '0;
      out_sat   <= 1'b0;
    end else if (!stall) begin
      out_vld <= s1_vld && s1_emit;
      if (s1_vld && s1_word) begin
        out_1_cnt <= ACC_LEN'(word_cnt);
        out_sat   <= 1'b0;
      end else if (s1_vld) begin
        acc_q <= acc_nxt;
        sat_q <= sat_nxt;
        if (s1_emit) begin
          out_1_cnt <= acc_nxt;
          out_sat   <= sat_nxt;
        end
      end
    end
  end

  // One-cycle pulse for each discarded word or abandoned partial frame.
  always_ff @(posedge sys_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_drop <= 1'b0;
    end else begin
      out_drop <= dec_drop;
    end
  end

endmodule

// File: tb/tb_count_1_pipe.sv
// tb_count_1_pipe: drives two count_1_pipe instances (ACC_LEN 16 / LANE 8 and
// ACC_LEN 6 / LANE 4) with identical traffic and scores both against a
// frame-level reference model through an expected-result queue.
module tb_count_1_pipe;
  import count_1_pkg::*;

  logic        sys_clk, in_rst_n, in_mode, in_vld, in_sof, in_eof, out_rdy;
  logic [31:0] in_dat;

  logic        in_rdy_a, out_vld_a, out_sat_a, out_drop_a;
  logic [15:0] out_1_cnt_a;
  logic        in_rdy_b, out_vld_b, out_sat_b, out_drop_b;
  logic [5:0]  out_1_cnt_b;

  typedef struct {
    int unsigned cnt_a;
    bit          sat_a;
    int unsigned cnt_b;
    bit          sat_b;
    int          exp_cyc;
    bit          timed;
  } exp_t;

  exp_t        sb_q[$];
  int          n_total = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          exp_drops = 0;
  int          obs_drops_a = 0;
  int          obs_drops_b = 0;
  bit          timing_on = 0;
  bit          m_in_frame = 0;
  int unsigned m_total = 0;

  count_1_pipe #(.IN_LEN(32), .LANE(8), .ACC_LEN(16)) dut_a (
    .sys_clk(sys_clk), .in_rst_n(in_rst_n), .in_mode(in_mode), .in_vld(in_vld),
    .in_rdy(in_rdy_a), .in_dat(in_dat), .in_sof(in_sof), .in_eof(in_eof),
    .out_vld(out_vld_a), .out_rdy(out_rdy), .out_1_cnt(out_1_cnt_a),
    .out_sat(out_sat_a), .out_drop(out_drop_a)
  );

  count_1_pipe #(.IN_LEN(32), .LANE(4), .ACC_LEN(6)) dut_b (
    .sys_clk(sys_clk), .in_rst_n(in_rst_n), .in_mode(in_mode), .in_vld(in_vld),
    .in_rdy(in_rdy_b), .in_dat(in_dat), .in_sof(in_sof), .in_eof(in_eof),
    .out_vld(out_vld_b), .out_rdy(out_rdy), .out_1_cnt(out_1_cnt_b),
    .out_sat(out_sat_b), .out_drop(out_drop_b)
  );

  // Free-running clock and cycle counter used for latency checks.
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_total++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Queue one expected result, clamped for each accumulator width.
  function automatic void pushResult(input int unsigned total);
    exp_t e;
    e.cnt_a   = (total > 65535) ? 65535 : total;
    e.sat_a   = (total > 65535);
    e.cnt_b   = (total > 63) ? 63 : total;
    e.sat_b   = (total > 63);
    e.exp_cyc = cyc + 2;
    e.timed   = timing_on;
    sb_q.push_back(e);
  endfunction

  // Reference behaviour of one accepted word, in frame terms.
  function automatic void modelAccept(input bit mode, input bit sof, input bit eof,
                                      input logic [31:0] dat);
    int unsigned pc;
    bit          eff_mode;
    pc       = $countones(dat);
    eff_mode = m_in_frame ? MODE_FRAME : mode;
    if (eff_mode == MODE_WORD) begin
      pushResult(pc);
    end else if (sof) begin
      if (m_in_frame) exp_drops++;
      m_total    = pc;
      m_in_frame = !eof;
      if (eof) pushResult(m_total);
    end else if (m_in_frame) begin
      m_total = m_total + pc;
      if (eof) begin
        pushResult(m_total);
        m_in_frame = 0;
      end
    end else begin
      exp_drops++;
    end
  endfunction

  // Drive one cycle of inputs; report whether the word was taken.
  task automatic applyStimulus(input bit vld, input bit mode, input bit sof,
                               input bit eof, input logic [31:0] dat,
                               input bit rdy, output bit accepted);
    @(negedge sys_clk);
    in_vld  = vld;
    in_mode = mode;
    in_sof  = sof;
    in_eof  = eof;
    in_dat  = dat;
    out_rdy = rdy;
    #1;
    accepted = vld && in_rdy_a && in_rst_n;
    if (accepted) modelAccept(mode, sof, eof, dat);
    @(posedge sys_clk);
  endtask

  task automatic sendWord(input bit mode, input bit sof, input bit eof,
                          input logic [31:0] dat);
    bit acc = 0;
    int tries = 0;
    while (!acc && tries < 50) begin
      applyStimulus(1, mode, sof, eof, dat, 1, acc);
      tries++;
    end
    if (!acc) checkOutput("send_accept", 32'(acc), 1);
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      applyStimulus(0, 0, 0, 0, 32'h0, 1, acc);
      n++;
    end
    repeat (3) applyStimulus(0, 0, 0, 0, 32'h0, 1, acc);
    checkOutput("drain_empty", 32'(sb_q.size()), 0);
    checkOutput("drops_a", 32'(obs_drops_a), 32'(exp_drops));
    checkOutput("drops_b", 32'(obs_drops_b), 32'(exp_drops));
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_vld_a",  32'(out_vld_a),   0);
    checkOutput("rst_cnt_a",  32'(out_1_cnt_a), 0);
    checkOutput("rst_sat_a",  32'(out_sat_a),   0);
    checkOutput("rst_drop_a", 32'(out_drop_a),  0);
    checkOutput("rst_rdy_a",  32'(in_rdy_a),    1);
    checkOutput("rst_vld_b",  32'(out_vld_b),   0);
    checkOutput("rst_cnt_b",  32'(out_1_cnt_b), 0);
    checkOutput("rst_rdy_b",  32'(in_rdy_b),    1);
  endtask

  // Monitor: counts drop pulses, checks hold-under-stall, pops the scoreboard.
  initial begin
    bit          prev_stall = 0;
    logic [15:0] prev_cnt_a = '0;
    logic [5:0]  prev_cnt_b = '0;
    logic        prev_sat_a = 0;
    logic        prev_sat_b = 0;
    exp_t        e;
    forever begin
      @(negedge sys_clk);
      #2;
      if (!in_rst_n) begin
        prev_stall = 0;
      end else begin
        if (out_drop_a) obs_drops_a++;
        if (out_drop_b) obs_drops_b++;
        if (prev_stall) begin
          checkOutput("hold_vld_a", 32'(out_vld_a),   1);
          checkOutput("hold_cnt_a", 32'(out_1_cnt_a), 32'(prev_cnt_a));
          checkOutput("hold_sat_a", 32'(out_sat_a),   32'(prev_sat_a));
          checkOutput("hold_cnt_b", 32'(out_1_cnt_b), 32'(prev_cnt_b));
          checkOutput("hold_sat_b", 32'(out_sat_b),   32'(prev_sat_b));
        end
        if (out_vld_a && !out_rdy) begin
          checkOutput("stall_rdy_a", 32'(in_rdy_a), 0);
          prev_stall = 1;
          prev_cnt_a = out_1_cnt_a;
          prev_cnt_b = out_1_cnt_b;
          prev_sat_a = out_sat_a;
          prev_sat_b = out_sat_b;
        end else begin
          prev_stall = 0;
        end
        if (out_vld_a && out_rdy) begin
          if (sb_q.size() == 0) begin
            checkOutput("unexpected_out", 32'(out_vld_a), 0);
          end else begin
            e = sb_q.pop_front();
            checkOutput("cnt_a", 32'(out_1_cnt_a), e.cnt_a);
            checkOutput("sat_a", 32'(out_sat_a),   32'(e.sat_a));
            checkOutput("vld_b", 32'(out_vld_b),   1);
            checkOutput("cnt_b", 32'(out_1_cnt_b), e.cnt_b);
            checkOutput("sat_b", 32'(out_sat_b),   32'(e.sat_b));
            if (e.timed) checkOutput("latency", 32'(cyc), 32'(e.exp_cyc));
          end
        end
      end
    end
  end

  // Hard stop if something hangs.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    bit acc;
    in_rst_n = 0;
    in_vld   = 0;
    in_mode  = 0;
    in_sof   = 0;
    in_eof   = 0;
    in_dat   = '0;
    out_rdy  = 1;
    repeat (3) @(negedge sys_clk);
    #1;
    checkResetOutputs();
    @(negedge sys_clk);
    in_rst_n = 1;

    $display("[TB] mode 0 back-to-back words");
    timing_on = 1;
    sendWord(MODE_WORD, 0, 0, 32'h0000_0000);
    sendWord(MODE_WORD, 1, 0, 32'h0000_0001);
    sendWord(MODE_WORD, 0, 1, 32'hFFFF_FFFF);
    sendWord(MODE_WORD, 0, 0, 32'h8000_0001);
    drain();

    $display("[TB] three-word frame, mode input changes mid-frame");
    sendWord(MODE_FRAME, 1, 0, 32'h0000_000F);
    sendWord(MODE_WORD,  0, 0, 32'hFF00_0000);
    sendWord(MODE_WORD,  0, 1, 32'hFFFF_FFFF);
    drain();

    $display("[TB] saturating frame");
    sendWord(MODE_FRAME, 1, 0, 32'hFFFF_FFFF);
    sendWord(MODE_FRAME, 0, 0, 32'hFFFF_FFFF);
    sendWord(MODE_FRAME, 0, 1, 32'hFFFF_FFFF);
    drain();

    $display("[TB] discards, restart and one-word frame");
    sendWord(MODE_FRAME, 0, 0, 32'h0000_FFFF);
    sendWord(MODE_FRAME, 1, 0, 32'h0000_00FF);
    sendWord(MODE_FRAME, 0, 0, 32'h0000_0FFF);
    sendWord(MODE_FRAME, 1, 0, 32'h0000_0007);
    sendWord(MODE_FRAME, 0, 1, 32'h0000_0030);
    sendWord(MODE_FRAME, 1, 1, 32'h1111_1111);
    drain();

    $display("[TB] output stall for five cycles");
    timing_on = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, MODE_WORD, 0, 0, $urandom(), !(i >= 2 && i < 7), acc);
    end
    drain();

    $display("[TB] reset in the middle of a frame");
    timing_on = 1;
    sendWord(MODE_FRAME, 1, 0, 32'hFFFF_FFFF);
    sendWord(MODE_FRAME, 0, 0, 32'h0000_00FF);
    @(negedge sys_clk);
    in_rst_n = 0;
    in_vld   = 0;
    #1;
    checkResetOutputs();
    m_in_frame = 0;
    m_total    = 0;
    sb_q.delete();
    repeat (2) @(negedge sys_clk);
    in_rst_n = 1;
    #1;
    checkOutput("rdy_after_reset", 32'(in_rdy_a), 1);
    applyStimulus(1, MODE_FRAME, 1, 1, 32'h0000_0003, 1, acc);
    checkOutput("first_accept", 32'(acc), 1);
    drain();

    $display("[TB] randomized traffic");
    timing_on = 0;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      int          k;
      k = $urandom_range(0, 3);
      d = (k == 0) ? 32'h0 : (k == 1) ? 32'hFFFF_FFFF : $urandom();
      applyStimulus($urandom_range(0, 99) < 85, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
                    d, $urandom_range(0, 99) < 70, acc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
